rr_idx_arbiter16: RTL and testbench

- 16-requester round-robin arbiter that produces a binary grant index plus a grant-enable.
- Sits directly upstream of the 4-to-16 enable-gated decoder: gnt_idx drives the decoder select and gnt_en drives its enable, so the decoder output becomes the one-hot grant vector.
- A grant is locked until the owner signals done, then rotates fairly.

---
 rtl/rr_idx_arbiter16_pkg.sv | 18 +
 rtl/rr_idx_arbiter16_if.sv | 22 ++
 rtl/rr_idx_arbiter16_pick.sv | 28 ++
 rtl/rr_idx_arbiter16.sv | 132 +++++++++++++
 tb/tb_rr_idx_arbiter16.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/rr_idx_arbiter16_pkg.sv
// Shared constants, FSM state type and index helper for the 16-way round-robin index arbiter.
package rr_arb_pkg;

  localparam int N_REQ           = 16;
  localparam int IDX_W           = 4;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Next index after the current owner; the natural 4-bit wrap makes 15 roll over to 0.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_idx_arbiter16_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_idx_arbiter16_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic             gnt_en;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt_en, gnt_idx, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt_en, gnt_idx, busy, timeout
  );

endinterface

// File: rtl/rr_idx_arbiter16_pick.sv
// Combinational circular find-first: first set req bit at or above ptr, wrapping past 15 to 0.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest set bit is the last one written.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, otherwise a latch is inferred.
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = ptr + IDX_W'(off);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_idx_arbiter16.sv
// Round-robin arbiter with locked grants, binary grant index and grant-enable.
// Optional forced release after TIMEOUT_CYC cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_idx_arbiter16 #(
  parameter int N_REQ       = 16,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = rr_arb_pkg::TIMEOUT_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  rr_idx_arbiter16_if.slave       bus
);

  if (N_REQ != 16 || IDX_W != 4 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("rr_idx_arbiter16 supports only N_REQ=16, IDX_W=4 and TIMEOUT_CYC>=1");
  end

  rr_arb_pkg::state_e state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_en_q, gnt_en_d;
  logic               busy_q, busy_d;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic               release_now;

  rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;
  logic             hold_at_limit;

  assign hold_at_limit = (hold_q == CNT_W'(TIMEOUT_CYC - 1));
  assign release_now   = bus.done | hold_at_limit;
`else
  assign release_now   = bus.done;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_en_d  = gnt_en_q;
    busy_d    = busy_q;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif

    unique case (state_q)
      rr_arb_pkg::IDLE: begin
        gnt_en_d = 1'b0;
        busy_d   = 1'b0;
        if (pick_any) begin
          state_d   = rr_arb_pkg::GRANT;
          gnt_idx_d = pick_idx;
          gnt_en_d  = 1'b1;
          busy_d    = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d    = '0;
`endif
        end
      end

      rr_arb_pkg::GRANT: begin
        // The owner keeps the grant whatever req does; only done (or the hold limit) ends it.
        if (release_now) begin
          state_d  = rr_arb_pkg::IDLE;
          gnt_en_d = 1'b0;
          busy_d   = 1'b0;
          ptr_d    = rr_arb_pkg::idx_inc(gnt_idx_q);
        end
`ifdef RR_ARB_TIMEOUT_EN
        // done on the limit edge is an ordinary release, so no timeout pulse then.
        timeout_d = hold_at_limit & ~bus.done;
        if (!release_now) begin
          hold_d = hold_q + CNT_W'(1);
        end
`endif
      end

      default: begin
        state_d = rr_arb_pkg::IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= rr_arb_pkg::IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_en_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_en_q  <= gnt_en_d;
      busy_q    <= busy_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt_en  = gnt_en_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_rr_idx_arbiter16.sv
// Bench for rr_idx_arbiter16: directed literal checks plus randomized traffic against a grant-level model.
module tb_rr_idx_arbiter16;

  localparam int TB_TO = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  rr_idx_arbiter16_if bus ();

  rr_idx_arbiter16 #(.TIMEOUT_CYC(TB_TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Grant-level model: who owns the resource, whose turn is next, how long the owner has held it.
  bit m_owned;
  int m_owner;
  int m_next;
  int m_held;
  bit m_to;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_owned = 1'b0; m_owner = 0; m_next = 0; m_held = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (!m_owned) begin
        for (int i = 0; i < 16; i++) begin
          if (bus.req[(m_next + i) % 16]) begin
            m_owner = (m_next + i) % 16;
            m_owned = 1'b1;
            m_held  = 1;
            break;
          end
        end
      end else if (bus.done || (TO_EN && m_held >= TB_TO)) begin
        m_to    = !bus.done;
        m_owned = 1'b0;
        m_next  = (m_owner + 1) % 16;
      end else begin
        m_held++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process against the model, every cycle out of reset.
  always @(negedge clk) begin
    if (rstn) begin
      check("mdl_gnt_en",  32'(bus.gnt_en),  32'(m_owned));
      check("mdl_gnt_idx", 32'(bus.gnt_idx), 32'(m_owner));
      check("mdl_busy",    32'(bus.busy),    32'(m_owned));
      check("mdl_timeout", 32'(bus.timeout), 32'(m_to));
    end
  end

  task automatic drive(input logic [15:0] r, input logic d);
    @(negedge clk);
    #1;
    bus.req  = r;
    bus.done = d;
  endtask

  task automatic lit(input string tag, input logic en, input logic [3:0] idx, input logic to);
    check({tag, "_en"},   32'(bus.gnt_en),  32'(en));
    check({tag, "_idx"},  32'(bus.gnt_idx), 32'(idx));
    check({tag, "_busy"}, 32'(bus.busy),    32'(en));
    check({tag, "_to"},   32'(bus.timeout), 32'(to));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rstn     = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    #2;
    lit("rst", 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  logic [15:0] r;

  initial begin
    bus.req  = '0;
    bus.done = 1'b0;
    do_reset();

    // Single requester 5: grant, release, regrant two edges after done.
    drive(16'h0020, 1'b0);
    drive(16'h0020, 1'b0); lit("t1_grant", 1'b1, 4'd5, 1'b0);
    drive(16'h0020, 1'b1); lit("t1_hold",  1'b1, 4'd5, 1'b0);
    drive(16'h0020, 1'b0); lit("t1_rel",   1'b0, 4'd5, 1'b0);
    drive(16'h0020, 1'b0); lit("t1_regnt", 1'b1, 4'd5, 1'b0);

    // All requesting with done held: 0..15,0 interleaved with idle cycles.
    do_reset();
    drive(16'hFFFF, 1'b1);
    for (int k = 0; k <= 16; k++) begin
      drive(16'hFFFF, 1'b1); lit("t2_on",  1'b1, 4'(k % 16), 1'b0);
      drive(16'hFFFF, 1'b1); lit("t2_off", 1'b0, 4'(k % 16), 1'b0);
    end

    // Two requesters 3 and 9 alternate.
    do_reset();
    drive(16'h0208, 1'b0);
    drive(16'h0208, 1'b1); lit("t3_g3a", 1'b1, 4'd3, 1'b0);
    drive(16'h0208, 1'b0); lit("t3_r3a", 1'b0, 4'd3, 1'b0);
    drive(16'h0208, 1'b1); lit("t3_g9",  1'b1, 4'd9, 1'b0);
    drive(16'h0208, 1'b0); lit("t3_r9",  1'b0, 4'd9, 1'b0);
    drive(16'h0208, 1'b1); lit("t3_g3b", 1'b1, 4'd3, 1'b0);
    drive(16'h0000, 1'b0); lit("t3_r3b", 1'b0, 4'd3, 1'b0);

    // Owner drops req, grant persists; done in IDLE leaves ptr alone.
    do_reset();
    drive(16'h0010, 1'b0);
    drive(16'h0000, 1'b0); lit("t4_g4",    1'b1, 4'd4, 1'b0);
    drive(16'h0000, 1'b0); lit("t4_lock",  1'b1, 4'd4, 1'b0);
    drive(16'h0000, 1'b1); lit("t4_lock2", 1'b1, 4'd4, 1'b0);
    drive(16'h0000, 1'b1); lit("t4_rel",   1'b0, 4'd4, 1'b0);
    drive(16'h0030, 1'b0); lit("t4_idone", 1'b0, 4'd4, 1'b0);
    drive(16'h0000, 1'b0); lit("t4_g5",    1'b1, 4'd5, 1'b0);

    // Asynchronous reset mid-grant, then grant 7 from ptr 0.
    do_reset();
    drive(16'h0080, 1'b0);
    drive(16'h0080, 1'b0); lit("t5_g7", 1'b1, 4'd7, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    lit("t5_arst", 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    drive(16'h0080, 1'b0); lit("t5_g7b", 1'b1, 4'd7, 1'b0);

    // Hold limit: four grant cycles, forced release, regrant after the idle cycle.
    do_reset();
    drive(16'h0002, 1'b0);
    for (int k = 0; k < TB_TO; k++) begin
      drive(16'h0002, 1'b0); lit("t6_hold", 1'b1, 4'd1, 1'b0);
    end
    drive(16'h0002, 1'b0);
    if (TO_EN) lit("t6_force", 1'b0, 4'd1, 1'b1);
    else       lit("t6_nofrc", 1'b1, 4'd1, 1'b0);
    drive(16'h0002, 1'b0);
    lit("t6_after", 1'b1, 4'd1, 1'b0);

    // Randomized traffic, checked every cycle by the compare process.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(3))
        0:       r = 16'($urandom);
        1:       r = 16'h1 << $urandom_range(15);
        2:       r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: r = '0;
      endcase
      drive(r, ($urandom_range(2) == 0));
    end

    drive(16'h0000, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
